// File: rtl/conv_mac_accum_if.sv
// Handshake bus for the convolution MAC accumulator: a product stream in, a normalized pixel result out.
interface conv_mac_accum_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_sat;
    logic [35:0] out_acc;

    modport master (
        output in_valid, in_prod, flush, out_ready,
        input  in_ready, out_valid, out_pixel, out_sat, out_acc
    );

    modport slave (
        input  in_valid, in_prod, flush, out_ready,
        output in_ready, out_valid, out_pixel, out_sat, out_acc
    );
endinterface

// File: rtl/conv_mac_accum.sv
// Sums TAPS unsigned products per output pixel, then rounds, shifts and saturates the sum to 8 bits.
module conv_mac_accum #(
    parameter int TAPS  = 9,
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    conv_mac_accum_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [35:0] r_acc;
    logic [3:0]  r_tapCnt;
    logic        r_outValid;
    logic [7:0]  r_outPixel;
    logic        r_outSat;
    logic [35:0] r_outAcc;

    logic        w_beat;
    logic        w_lastBeat;
    logic [35:0] w_sum;
    logic [36:0] w_rounded;
    logic [36:0] w_shifted;
    logic        w_sat;
    logic [7:0]  w_pixel;

    assign w_beat     = bus.in_valid && (r_state != HOLD);
    assign w_lastBeat = (r_state == ACCUM) && (r_tapCnt == 4'(TAPS - 1));

    // 36 bits holds 15 full-scale products, so the running sum never wraps.
    assign w_sum     = r_acc + {4'b0, bus.in_prod};
    assign w_rounded = {1'b0, w_sum} + (37'd1 << (SHIFT - 1));
    assign w_shifted = w_rounded >> SHIFT;
    assign w_sat     = |w_shifted[36:8];
    assign w_pixel   = w_sat ? 8'hFF : w_shifted[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_tapCnt   <= '0;
            r_outValid <= 1'b0;
            r_outPixel <= '0;
            r_outSat   <= 1'b0;
            r_outAcc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        r_acc    <= '0;
                        r_tapCnt <= '0;
                    end else if (w_beat) begin
                        r_acc    <= {4'b0, bus.in_prod};
                        r_tapCnt <= 4'd1;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.flush) begin
                        r_acc    <= '0;
                        r_tapCnt <= '0;
                        r_state  <= IDLE;
                    end else if (w_beat) begin
                        r_acc    <= w_sum;
                        r_tapCnt <= r_tapCnt + 4'd1;
                        if (w_lastBeat) begin
                            r_state    <= HOLD;
                            r_outValid <= 1'b1;
                            r_outAcc   <= w_sum;
                            r_outPixel <= w_pixel;
                            r_outSat   <= w_sat;
                        end
                    end
                end
                HOLD: begin
                    // Result stays put until downstream takes it; flush has no effect here.
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_acc      <= '0;
                        r_tapCnt   <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state != HOLD);
    assign bus.out_valid = r_outValid;
    assign bus.out_pixel = r_outPixel;
    assign bus.out_sat   = r_outSat;
    assign bus.out_acc   = r_outAcc;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: table of full nine-beat sums plus hold, flush and reset sequences.
module tb_conv_mac_accum;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    conv_mac_accum_if bus ();

    conv_mac_accum #(.TAPS(9), .SHIFT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] first;
        logic [31:0] rest;
        int          gap;
        logic [35:0] expAcc;
        logic [7:0]  expPix;
        logic        expSat;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One beat is accepted on the next rising edge; signals are released just after it.
    task automatic applyStimulus(input logic [31:0] prod);
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResult(input string name, input logic [35:0] acc, input logic [7:0] pix, input logic sat);
        checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({name, " in_ready"},  64'(bus.in_ready),  64'd0);
        checkOutput({name, " out_acc"},   64'(bus.out_acc),   64'(acc));
        checkOutput({name, " out_pixel"}, 64'(bus.out_pixel), 64'(pix));
        checkOutput({name, " out_sat"},   64'(bus.out_sat),   64'(sat));
    endtask

    task automatic checkCleared(input string name);
        checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({name, " out_acc"},   64'(bus.out_acc),   64'd0);
        checkOutput({name, " out_pixel"}, 64'(bus.out_pixel), 64'd0);
        checkOutput({name, " out_sat"},   64'(bus.out_sat),   64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{"all256",   32'd256,        32'd256,        0, 36'd2304,        8'd9,   1'b0};
        vecs[1] = '{"half",     32'd128,        32'd0,          0, 36'd128,         8'd1,   1'b0};
        vecs[2] = '{"allOnes",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 36'd38654705655, 8'd255, 1'b1};
        vecs[3] = '{"below",    32'd127,        32'd0,          0, 36'd127,         8'd0,   1'b0};
        vecs[4] = '{"edge255",  32'd65152,      32'd0,          0, 36'd65152,       8'd255, 1'b0};
        vecs[5] = '{"edge256",  32'd65408,      32'd0,          0, 36'd65408,       8'd255, 1'b1};
        vecs[6] = '{"gapped",   32'd1000,       32'd1000,       2, 36'd9000,        8'd35,  1'b0};

        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        #1;
        checkCleared("reset");
        #11;
        rst = 1'b0;
        #1;
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);

        // Zero-valued products count as taps.
        applyStimulus(32'd0);
        idleCycles(1);
        for (int k = 1; k < 9; k++) applyStimulus(32'd0);
        checkResult("zeros", 36'd0, 8'd0, 1'b0);
        bus.out_ready = 1'b1;
        idleCycles(1);

        for (int v = 0; v < 7; v++) begin
            bus.out_ready = 1'b1;
            for (int k = 0; k < 9; k++) begin
                if (k == 8) checkOutput({vecs[v].name, " early valid"}, 64'(bus.out_valid), 64'd0);
                applyStimulus(k == 0 ? vecs[v].first : vecs[v].rest);
                if (k < 8) idleCycles(vecs[v].gap);
            end
            checkResult(vecs[v].name, vecs[v].expAcc, vecs[v].expPix, vecs[v].expSat);
            idleCycles(1);
            checkOutput({vecs[v].name, " drained"}, 64'(bus.out_valid), 64'd0);
        end

        // Result held under backpressure; beats and flush during HOLD must be ignored.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) applyStimulus(32'd300);
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 32'd5000;
            bus.flush    = 1'b1;
            checkResult("hold", 36'd2700, 8'd11, 1'b0);
            idleCycles(1);
        end
        checkResult("hold end", 36'd2700, 8'd11, 1'b0);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        idleCycles(1);
        checkOutput("hold release valid", 64'(bus.out_valid), 64'd0);
        checkOutput("hold release ready", 64'(bus.in_ready),  64'd1);

        // Flush mid-accumulation discards the partial sum and the simultaneous beat.
        for (int k = 0; k < 4; k++) applyStimulus(32'd1000);
        bus.flush = 1'b1;
        applyStimulus(32'd999);
        bus.flush = 1'b0;
        checkOutput("flush valid", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 9; k++) applyStimulus(32'd256);
        checkResult("after flush", 36'd2304, 8'd9, 1'b0);
        idleCycles(1);

        // Asynchronous reset while a result is pending.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) applyStimulus(32'd1000);
        checkResult("pre reset", 36'd9000, 8'd35, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("reset in hold");
        #2;
        rst = 1'b0;

        // Asynchronous reset mid-accumulation, then a fresh sum.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus(32'd512);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("reset in accum");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("post reset in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 9; k++) applyStimulus(32'd512);
        checkResult("after reset", 36'd4608, 8'd18, 1'b0);
        idleCycles(1);
        checkOutput("final drained", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_mac_accum.md
CONV_MAC_ACCUM -- requirements
Module: conv_mac_accum

Interface
REQ-001 Parameter TAPS, default 9: number of products summed per output pixel; legal range 2..15.
REQ-002 Parameter SHIFT, default 8: normalization right-shift applied to the sum; legal range 1..27.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 in_valid  input  1  in_prod holds a valid 32-bit unsigned product.
REQ-006 in_ready  output  1  block accepts a product this cycle.
REQ-007 in_prod  input  32  unsigned product from the 16x16 multiplier.
REQ-008 flush  input  1  synchronous abort of any partial accumulation.
REQ-009 out_valid  output  1  out_pixel, out_sat and out_acc are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_pixel  output  8  rounded, shifted, saturated pixel.
REQ-012 out_sat  output  1  saturation occurred on out_pixel.
REQ-013 out_acc  output  36  raw unsigned sum of the TAPS products.

Function
REQ-014 Input beat accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-015 FSM states: IDLE (count 0, no data), ACCUM (1..TAPS-1 beats held), HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 IDLE->ACCUM on an accepted beat: accumulator loads zero-extended in_prod; tap counter = 1.
REQ-018 In ACCUM, each accepted beat adds zero-extended in_prod to the accumulator; tap counter increments.
REQ-019 Accepting beat number TAPS moves the FSM to HOLD and asserts out_valid the next cycle; latency from the final accepted beat to out_valid is exactly 1 cycle.
REQ-020 Accumulator is 36 bits wide; the sum cannot overflow for TAPS<=15; no wrap-around permitted.
REQ-021 out_pixel = min(255, (acc + 2^(SHIFT-1)) >> SHIFT); rounding add uses 37 bits; out_sat = 1 only when the rounded value exceeds 255.
REQ-022 out_pixel, out_sat and out_acc are registered, set at the HOLD transition, and stay stable while out_valid=1 and out_ready=0.
REQ-023 HOLD->IDLE on the cycle that out_valid and out_ready are both 1; out_valid falls and the tap counter clears on that edge.
REQ-024 out_valid holds 1 for as long as out_ready is 0; no result is ever dropped or overwritten.
REQ-025 flush=1 in IDLE or ACCUM clears the accumulator and tap counter and moves to IDLE; a beat presented in the same cycle is discarded; out_* unchanged.
REQ-026 flush is ignored in HOLD.
REQ-027 in_valid=0 in ACCUM leaves state, counter and accumulator unchanged; gaps between beats are allowed.
REQ-028 Products of value 0 count as beats toward TAPS.

Reset
REQ-029 rst=1 immediately forces IDLE, tap counter 0, accumulator 0, out_valid 0, out_pixel 0, out_sat 0, out_acc 0; in_ready is 1 once rst deasserts.
REQ-030 rst asserted mid-accumulation or in HOLD discards all partial and pending results; the first beat after release starts a new sum.

Verification
REQ-031 Nine beats of in_prod=256, out_ready=1 -> one cycle after beat 9: out_valid=1, out_acc=2304, out_pixel=9, out_sat=0.
REQ-032 Beat 1 = 128, beats 2..9 = 0 -> out_acc=128, out_pixel=1 (round half up), out_sat=0.
REQ-033 Nine beats of 0xFFFFFFFF -> out_acc=38654705655, out_pixel=255, out_sat=1.
REQ-034 Result held with out_ready=0 for 3 cycles -> out_valid, out_pixel, out_acc stable and in_ready=0 throughout; handshake on cycle 4 -> out_valid=0 and in_ready=1 next cycle.
REQ-035 Four beats of 1000, then flush=1 with in_valid=1, then nine beats of 256 -> out_acc=2304, not 6304.
REQ-036 Five beats accepted, rst pulsed asynchronously between clock edges -> all outputs 0 immediately; nine subsequent beats of 512 -> out_acc=4608, out_pixel=18.
